pipelined_ctrl_decoder: RTL

PIPELINED_CTRL_DECODER -- requirements
Module: pipelined_ctrl_decoder

---
 rtl/cpu_ctrl_pkg.sv | 75 +++++++
 rtl/return_addr_stack.sv | 46 ++++
 rtl/pipelined_ctrl_decoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode constants, immediate/ALU encodings, ctrl_t and the base decode table
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_I    = 3'd1;
    localparam logic [2:0] OP_S    = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_BNE  = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd5;
    localparam logic [2:0] OP_CALL = 3'd6;
    localparam logic [2:0] OP_RET  = 3'd7;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b01;
    localparam logic [1:0] IMM_J    = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic       jump;
        logic       call;
        logic       ret;
        logic [1:0] imm_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Covers the eight defined opcodes; callers zero the result for wider unknown opcodes.
    function automatic ctrl_t decode_op(input logic [2:0] op);
        ctrl_t c;
        c = '0;
        c.imm_src = IMM_NONE;
        c.alu_op  = ALU_ADD;
        case (op)
            OP_R: c.reg_write = 1'b1;
            OP_I: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = 1'b1;
                c.imm_src    = IMM_I;
            end
            OP_S: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.imm_src   = IMM_I;
            end
            OP_BEQ, OP_BNE: begin
                c.branch  = 1'b1;
                c.imm_src = IMM_I;
                c.alu_op  = ALU_SUB;
            end
            OP_JMP: begin
                c.jump    = 1'b1;
                c.imm_src = IMM_J;
            end
            OP_CALL: begin
                c.jump    = 1'b1;
                c.call    = 1'b1;
                c.imm_src = IMM_J;
            end
            OP_RET: begin
                c.jump = 1'b1;
                c.ret  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] data,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    // Top of stack sits just below the next free slot; when full, wr_ptr points at the oldest entry.
    assign data  = mem[wr_ptr - PW'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!full)
                count <= count + (PW+1)'(1);
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PW'(1);
            count  <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipelined_ctrl_decoder.sv
// rtl/pipelined_ctrl_decoder.sv - one-stage registered control decoder; PIPELINED_CTRL_DECODER_RAS_EN enables the return-address stack
module pipelined_ctrl_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W      = 5,
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_ctrl,
    output logic [ADDR_W-1:0] out_ret_addr,
    output logic              out_illegal,
    output logic              ras_ovf,
    output logic              ras_udf
);

    logic              accept;
    logic              legal_op;
    ctrl_t             dec;
    logic [ADDR_W-1:0] ret_addr_d;
    logic              udf_now;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign legal_op = (in_op[OP_W-1:3] == '0);
    assign dec      = legal_op ? decode_op(in_op[2:0]) : '0;

`ifdef PIPELINED_CTRL_DECODER_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic              ras_empty;
    logic              ras_full;
    logic [ADDR_W-1:0] ras_data;

    assign ras_push   = accept && dec.call;
    assign ras_pop    = accept && dec.ret;
    assign udf_now    = ras_pop && ras_empty;
    assign ret_addr_d = (ras_pop && !ras_empty) ? ras_data : '0;

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (in_pc + ADDR_W'(1)),
        .data      (ras_data),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ovf <= 1'b0;
            ras_udf <= 1'b0;
        end else begin
            if (ras_push && ras_full)
                ras_ovf <= 1'b1;
            if (udf_now)
                ras_udf <= 1'b1;
        end
    end
`else
    logic unused_pc;
    localparam int UNUSED_DEPTH = RAS_DEPTH;

    assign unused_pc  = ^in_pc;
    assign ret_addr_d = '0;
    assign udf_now    = 1'b0;
    assign ras_ovf    = 1'b0;
    assign ras_udf    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_ctrl     <= '0;
            out_ret_addr <= '0;
            out_illegal  <= 1'b0;
        end else begin
            if (accept) begin
                out_ctrl     <= dec;
                out_ret_addr <= ret_addr_d;
                out_illegal  <= !legal_op || udf_now;
            end
            if (flush)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
